// File: rtl/gain_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gain_pkg : shared types/constants for the gain controller & datapath |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package gain_pkg;

  typedef enum logic [1:0] {
    DB_IDLE    = 2'd0,
    DB_PRESS   = 2'd1,
    DB_HELD    = 2'd2,
    DB_RELEASE = 2'd3
  } db_state_e;

  typedef logic [1:0] level_t;

  localparam level_t LEVEL_MIN = 2'd0;
  localparam level_t LEVEL_MAX = 2'd3;

  // Moves one level toward tgt; never wraps across the MIN/MAX boundary.
  function automatic level_t step_toward(input level_t cur, input level_t tgt);
    if ((cur < tgt) && (cur != LEVEL_MAX)) return cur + 2'd1;
    if ((cur > tgt) && (cur != LEVEL_MIN)) return cur - 2'd1;
    return cur;
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | btn_debounce : 2-flop sync + debounce FSM, one press pulse per press |
// | Macro GAIN_LONG_PRESS_EN adds a one-shot long-hold pulse.  Rev 1.0   |
// +----------------------------------------------------------------------+
module btn_debounce
  import gain_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
`ifdef GAIN_LONG_PRESS_EN
  , parameter int LONG_CYCLES = 1000000
`endif
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic button_i,
  output logic press_o
`ifdef GAIN_LONG_PRESS_EN
  , output logic long_o
`endif
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] c_db_last = DW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          btn_s;
  db_state_e     state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

`ifdef GAIN_LONG_PRESS_EN
  localparam int LW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [LW-1:0] c_long_last = LW'(LONG_CYCLES - 1);

  logic [LW-1:0] lcnt_q, lcnt_d;
  logic          fired_q, fired_d;
  logic          long_q, long_d;
`endif

  assign btn_s   = sync_q[1];
  assign press_o = press_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= 2'b00;
      state_q <= DB_IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], button_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    case (state_q)
      DB_IDLE: begin
        if (btn_s) begin
          state_d = DB_PRESS;
          cnt_d   = '0;
        end
      end
      DB_PRESS: begin
        if (!btn_s) begin
          state_d = DB_IDLE;
        end else if (cnt_q == c_db_last) begin
          state_d = DB_HELD;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DB_HELD: begin
        if (!btn_s) begin
          state_d = DB_RELEASE;
          cnt_d   = '0;
        end
      end
      DB_RELEASE: begin
        if (btn_s) begin
          state_d = DB_HELD;
        end else if (cnt_q == c_db_last) begin
          state_d = DB_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = DB_IDLE;
    endcase
  end

`ifdef GAIN_LONG_PRESS_EN
  assign long_o = long_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lcnt_q  <= '0;
      fired_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      lcnt_q  <= lcnt_d;
      fired_q <= fired_d;
      long_q  <= long_d;
    end
  end

  // Hold timer restarts only on a freshly accepted press, so a release bounce
  // back into HELD cannot re-arm the one-shot.
  always_comb begin
    lcnt_d  = lcnt_q;
    fired_d = fired_q;
    long_d  = 1'b0;
    if (press_d) begin
      lcnt_d  = '0;
      fired_d = 1'b0;
    end else if ((state_q == DB_HELD) && !fired_q) begin
      if (lcnt_q == c_long_last) begin
        long_d  = 1'b1;
        fired_d = 1'b1;
      end else begin
        lcnt_d = lcnt_q + 1'b1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/gain_level_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gain_level_ctrl : button-driven 4-level gain target + sample ramp    |
// | Macro GAIN_LONG_PRESS_EN: long hold clears target.  Rev 1.0          |
// +----------------------------------------------------------------------+
module gain_level_ctrl
  import gain_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int RAMP_SAMPLES    = 64
`ifdef GAIN_LONG_PRESS_EN
  , parameter int LONG_CYCLES   = 1000000
`endif
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       button_i,
  input  logic       sample_strobe_i,
  input  logic       bypass_i,
  output logic [1:0] level_tgt_o,
  output logic [1:0] level_cur_o,
  output logic       apply_strobe_o,
  output logic       ramping_o
);

  localparam int RW = (RAMP_SAMPLES > 1) ? $clog2(RAMP_SAMPLES) : 1;
  localparam logic [RW-1:0] c_rc_last = RW'(RAMP_SAMPLES - 1);

  logic          press;
  level_t        tgt_q, tgt_d;
  level_t        cur_q, cur_d;
  level_t        eff_tgt;
  logic [RW-1:0] rc_q, rc_d;
  logic          apply_q, apply_d;

`ifdef GAIN_LONG_PRESS_EN
  logic long_hold;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .LONG_CYCLES    (LONG_CYCLES)
  ) u_debounce (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .button_i(button_i),
    .press_o (press),
    .long_o  (long_hold)
  );
`else
  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .button_i(button_i),
    .press_o (press)
  );
`endif

  assign eff_tgt        = bypass_i ? LEVEL_MIN : tgt_q;
  assign level_tgt_o    = tgt_q;
  assign level_cur_o    = cur_q;
  assign apply_strobe_o = apply_q;
  assign ramping_o      = (cur_q != eff_tgt);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tgt_q   <= LEVEL_MIN;
      cur_q   <= LEVEL_MIN;
      rc_q    <= '0;
      apply_q <= 1'b0;
    end else begin
      tgt_q   <= tgt_d;
      cur_q   <= cur_d;
      rc_q    <= rc_d;
      apply_q <= apply_d;
    end
  end

  always_comb begin
    tgt_d = tgt_q;
    if (press) begin
      tgt_d = tgt_q + 2'd1;
    end
`ifdef GAIN_LONG_PRESS_EN
    if (long_hold) begin
      tgt_d = LEVEL_MIN;
    end
`endif
  end

  // Steps read the registered target, so a press landing on a step cycle is
  // only seen at the following step.
  always_comb begin
    cur_d   = cur_q;
    rc_d    = rc_q;
    apply_d = 1'b0;
    if (sample_strobe_i) begin
      if ((rc_q == c_rc_last) && (cur_q != eff_tgt)) begin
        cur_d   = step_toward(cur_q, eff_tgt);
        apply_d = 1'b1;
        rc_d    = '0;
      end else if (rc_q != c_rc_last) begin
        rc_d = rc_q + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gain_level_ctrl.sv
`default_nettype none
// Self-checking bench for gain_level_ctrl: event-level reference model
// (presses, strobes, bypass, reset) with directed and random sequences.
module tb_gain_level_ctrl;

  localparam int D = 8;
  localparam int R = 4;
  localparam int L = 40;

  logic       clk_i           = 1'b0;
  logic       rst_ni          = 1'b0;
  logic       button_i        = 1'b0;
  logic       sample_strobe_i = 1'b0;
  logic       bypass_i        = 1'b0;
  logic [1:0] level_tgt_o;
  logic [1:0] level_cur_o;
  logic       apply_strobe_o;
  logic       ramping_o;

  int n_checks = 0;
  int n_errors = 0;

  int m_tgt = 0;
  int m_cur = 0;
  int m_rc  = 0;
  bit m_byp = 1'b0;

  always #5 clk_i = ~clk_i;

  gain_level_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .RAMP_SAMPLES   (R)
`ifdef GAIN_LONG_PRESS_EN
    , .LONG_CYCLES  (L)
`endif
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .button_i       (button_i),
    .sample_strobe_i(sample_strobe_i),
    .bypass_i       (bypass_i),
    .level_tgt_o    (level_tgt_o),
    .level_cur_o    (level_cur_o),
    .apply_strobe_o (apply_strobe_o),
    .ramping_o      (ramping_o)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic int eff_target();
    return m_byp ? 0 : m_tgt;
  endfunction

  // hold <= D-1 is a glitch; hold in [D+6, D+L) is a short press.
  task automatic do_press(input int hold);
    button_i = 1'b1;
    repeat (hold) tick();
    button_i = 1'b0;
    repeat (D + 6) tick();
    if (hold >= D + 6) m_tgt = (m_tgt + 1) % 4;
    check("tgt_after_press", level_tgt_o, m_tgt);
    check("cur_quiet", level_cur_o, m_cur);
  endtask

  task automatic do_long();
    int hold;
    hold = L + 20;
    button_i = 1'b1;
    repeat (D + 8) tick();
    m_tgt = (m_tgt + 1) % 4;
    check("tgt_long_mid", level_tgt_o, m_tgt);
    repeat (hold - (D + 8)) tick();
    button_i = 1'b0;
    repeat (D + 6) tick();
`ifdef GAIN_LONG_PRESS_EN
    m_tgt = 0;
`endif
    check("tgt_long_end", level_tgt_o, m_tgt);
  endtask

  task automatic do_strobe(input int gap);
    int eff;
    int exp_apply;
    sample_strobe_i = 1'b1;
    tick();
    sample_strobe_i = 1'b0;
    eff       = eff_target();
    exp_apply = 0;
    if (m_rc == R - 1 && m_cur != eff) begin
      m_cur     = (eff > m_cur) ? m_cur + 1 : m_cur - 1;
      m_rc      = 0;
      exp_apply = 1;
    end else if (m_rc < R - 1) begin
      m_rc++;
    end
    check("apply", apply_strobe_o, exp_apply);
    check("cur", level_cur_o, m_cur);
    check("ramping", ramping_o, (m_cur != eff) ? 1 : 0);
    tick();
    check("apply_drop", apply_strobe_o, 0);
    repeat (gap - 1) tick();
  endtask

  task automatic set_bypass(input bit b);
    bypass_i = b;
    m_byp    = b;
    tick();
    check("ramping_byp", ramping_o, (m_cur != eff_target()) ? 1 : 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_tgt"}, level_tgt_o, 0);
    check({tag, "_cur"}, level_cur_o, 0);
    check({tag, "_apply"}, apply_strobe_o, 0);
    check({tag, "_ramping"}, ramping_o, 0);
  endtask

  initial begin
    int op;
    int guard;

    rst_ni = 1'b0;
    #2;
    check_zero("reset");
    repeat (3) tick();
    rst_ni = 1'b1;
    tick();

    // glitch rejected, then clean press ramps to 1 on the 4th strobe
    do_press(5);
    do_press(D + 8);
    repeat (4) do_strobe(9);

    // up toward 3, then a wrap press sends the ramp back down stepwise
    do_press(D + 8);
    do_press(D + 8);
    repeat (6) do_strobe(9);
    do_press(D + 8);
    repeat (16) do_strobe(9);

    // reach 3, bypass down to 0 with target retained, then back up
    repeat (3) do_press(D + 8);
    repeat (14) do_strobe(3);
    check("cur_at_max", level_cur_o, 3);
    set_bypass(1'b1);
    repeat (14) do_strobe(3);
    check("tgt_kept", level_tgt_o, 3);
    set_bypass(1'b0);
    repeat (14) do_strobe(3);

    // asynchronous reset mid-ramp at level 2
    set_bypass(1'b1);
    guard = 0;
    while (m_cur != 2 && guard < 20) begin
      do_strobe(2);
      guard++;
    end
    check("cur_before_reset", level_cur_o, 2);
    #2 rst_ni = 1'b0;
    #1;
    bypass_i = 1'b0;
    m_byp = 1'b0;
    m_tgt = 0;
    m_cur = 0;
    m_rc  = 0;
    check_zero("async_reset");
    repeat (2) tick();
    rst_ni = 1'b1;
    repeat (8) do_strobe(2);

    // long hold starting from target 2
    do_press(D + 8);
    do_press(D + 8);
    do_long();
    repeat (10) do_strobe(2);

    // random mix of presses, glitches, bypass toggles and strobes
    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 9);
      if (op <= 1)      do_press($urandom_range(D + 6, D + 20));
      else if (op == 2) do_press($urandom_range(1, D - 1));
      else if (op == 3) set_bypass(~m_byp);
      else              do_strobe($urandom_range(1, 12));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/gain_level_ctrl.md
Name: gain_level_ctrl

Overview:
- Controller that sequences the pedal's 4-level gain stage from a raw footswitch/push-button.
- Debounces the button and advances a target level 0→1→2→3→0 on each press.
- Ramps the applied level toward the target one step at a time, only on audio sample boundaries, so the gain change never lands mid-sample and never jumps more than one level (click suppression).
- Sits between the board I/O and the gain datapath: drives its shift amount, and drives the volume indicator LEDs.

Parameters:
- DEBOUNCE_CYCLES, 50000, clock cycles Button must be stable before a level change is accepted.
- RAMP_SAMPLES, 64, sample strobes between successive one-step changes of the applied level.
- LONG_CYCLES, 1000000, hold time for the long-press return-to-zero; used only with the optional feature.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous active-low reset.
- Button  in  1  raw button, active-high, asynchronous to Clk.
- Sample_strobe  in  1  one-cycle pulse per new audio sample from the codec interface.
- Bypass  in  1  forces the applied level to 0 while high. Target level is retained.
- Level_tgt  out  2  target level (user selection).
- Level_cur  out  2  applied level; drives the datapath shift amount and the volume LEDs.
- Apply_strobe  out  1  one-cycle pulse in the cycle Level_cur changes.
- Ramping  out  1  high while Level_cur != effective target.

Behaviour:
- Reset (Reset_n low, asynchronous):
  - All outputs 0, FSM in IDLE, all counters cleared.
  - Reset asserted mid-ramp or mid-debounce abandons the operation. No Apply_strobe is emitted.
- Synchroniser: Button passes through a 2-flop synchroniser; downstream logic sees btn_s only.
- Debounce FSM, states IDLE, PRESS_DB, HELD, RELEASE_DB:
  - IDLE: btn_s=1 → PRESS_DB, counter cleared.
  - PRESS_DB: counter increments each cycle while btn_s=1.
    - btn_s=0 → IDLE (glitch rejected).
    - Counter reaches DEBOUNCE_CYCLES-1 → HELD, and a one-cycle press pulse is generated.
  - HELD: btn_s=0 → RELEASE_DB, counter cleared.
  - RELEASE_DB: btn_s=1 → HELD. Counter reaches DEBOUNCE_CYCLES-1 with btn_s=0 → IDLE.
  - Exactly one press pulse per accepted press, regardless of how long the button is held.
- Target level:
  - Press pulse: Level_tgt <= Level_tgt+1, mod 4 (3 wraps to 0).
  - Registered, so it changes the cycle after the press pulse.
- Effective target: 0 if Bypass=1, else Level_tgt.
- Ramp engine:
  - Sample counter rc counts Sample_strobe pulses, saturating at RAMP_SAMPLES-1.
  - On a Sample_strobe cycle with rc==RAMP_SAMPLES-1 and Level_cur != effective target:
    - Level_cur steps ±1 toward the effective target.
    - Apply_strobe pulses in the same cycle Level_cur updates.
    - rc clears.
  - The first step after idle waits for rc to saturate. rc keeps counting while Level_cur == effective target, so a new target is served at the next strobe if rc is already saturated.
  - 3→0 wraps ramp downward 3,2,1,0. The ramp never wraps across 3↔0.
  - Target change mid-ramp: the direction is re-evaluated at each step. No step is skipped and no step is reversed twice.
- Ramping is combinational: Level_cur != effective target.
- Simultaneous events:
  - A press pulse and a step in the same cycle: the step uses the old Level_tgt.
  - Bypass assertion while ramping up reverses the direction at the next step.
- Sample_strobe with no pending change has no effect except the rc update.
- Latency, press to first applied step: ≤ 2 sync + DEBOUNCE_CYCLES + 1 + RAMP_SAMPLES sample periods.

Optional Feature:
- Macro GAIN_LONG_PRESS_EN.
- Defined:
  - Held counter runs in HELD.
  - On reaching LONG_CYCLES-1, Level_tgt <= 0 (one-shot per hold).
  - The short-press increment already applied is kept as an intermediate value and then overridden by the clear.
- Undefined: the counter and the LONG_CYCLES logic are absent; hold duration is irrelevant.

Decomposition:
- Shared package gain_pkg:
  - Debounce state enum typedef.
  - Level typedef (logic [1:0]).
  - Constants LEVEL_MIN=0 and LEVEL_MAX=3.
  - gain_pkg is also used by the gain datapath.
- Sub-module btn_debounce holds the synchroniser, the debounce FSM, and the press-pulse output (plus the long-press pulse under the macro).
- The ramp engine and the target register stay in the top module.

Test Plan:
- Clean press with DEBOUNCE_CYCLES=8, RAMP_SAMPLES=4, strobe every 10 cycles → Level_tgt goes 0→1; Level_cur=1 on the 4th strobe after rc clears; exactly one Apply_strobe.
- 5-cycle glitch on Button → no press; Level_tgt stays 0; FSM returns to IDLE.
- Four presses in quick succession → Level_tgt goes 1,2,3,0. Level_cur ramps up toward 3, then back down to 0, one step per 4 strobes, never jumping 3→0.
- Bypass=1 at Level_cur=3 → 3 Apply_strobes down to 0, Level_tgt remains 3. Bypass=0 → ramps back to 3.
- Reset_n low mid-ramp at Level_cur=2 → all outputs 0 immediately, asynchronously. After release, no spurious Apply_strobe.
- GAIN_LONG_PRESS_EN with LONG_CYCLES=40: hold 60 cycles at Level_tgt=2 → Level_tgt goes 3, then 0. Without the macro → stays 3.
